multicycle_controller: RTL



---
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the EnDMe accumulator processor.
// Optional macro MEM_TIMEOUT_EN: abort a MEM access after TIMEOUT cycles without mem_ready.
module multicycle_controller #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               instr_valid,
    input  logic               TYP,
    input  logic [OP_W-1:0]    OP,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic               ir_load,
    output logic               pc_en,
    output logic               br_ctrl,
    output logic               regwrite_ctrl,
    output logic [ALUOP_W-1:0] aluop_ctrl,
    output logic               memread_ctrl,
    output logic               memwrite_ctrl,
    output logic [1:0]         acc_ctrl,
    output logic               acc_we,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ALU, K_LD, K_ST, K_BZ, K_BR, K_MOVA, K_MOVR, K_NOP, K_HALT, K_IMM, K_ILL
    } kind_t;

    // M-type ignores OP entirely; any O-type bit above bit 3 is illegal.
    function automatic kind_t classify(input logic typ, input logic [OP_W-1:0] op);
        if (typ) return K_IMM;
        if ((op >> 4) != '0) return K_ILL;
        if (!op[3]) return K_ALU;
        case (op[2:0])
            3'd0:    return K_LD;
            3'd1:    return K_ST;
            3'd2:    return K_BZ;
            3'd3:    return K_BR;
            3'd4:    return K_MOVA;
            3'd5:    return K_MOVR;
            3'd6:    return K_NOP;
            default: return K_HALT;
        endcase
    endfunction

    state_t             r_state;
    logic               r_typ;
    logic [OP_W-1:0]    r_op;
    logic               r_ir_load, r_pc_en, r_br, r_regwrite, r_memread, r_memwrite;
    logic [ALUOP_W-1:0] r_aluop;
    logic [1:0]         r_acc_ctrl;
    logic               r_acc_we, r_busy, r_halted, r_illegal, r_timeout;
    kind_t              w_kind, w_new_kind;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   r_mem_cnt;
`endif

    assign w_kind     = classify(r_typ, r_op);
    assign w_new_kind = classify(TYP, OP);

    // ir_load is high in every FETCH cycle; the IR captures on the edge that accepts instr_valid.
    always_ff @(posedge clk) begin
        // NOTE: every output defaults to 0 here, so each is a one-cycle registered strobe
        // unless the transition below re-asserts it; nothing can be left latched from a prior state.
        r_ir_load  <= 1'b0;
        r_pc_en    <= 1'b0;
        r_br       <= 1'b0;
        r_regwrite <= 1'b0;
        r_aluop    <= '0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_acc_ctrl <= 2'b00;
        r_acc_we   <= 1'b0;
        r_busy     <= 1'b0;
        r_halted   <= 1'b0;
        r_illegal  <= 1'b0;
        r_timeout  <= 1'b0;
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_typ   <= 1'b0;
            r_op    <= '0;
`ifdef MEM_TIMEOUT_EN
            r_mem_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_ir_load <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_busy <= 1'b1;
                    if (instr_valid) begin
                        r_typ   <= TYP;
                        r_op    <= OP;
                        r_state <= S_DECODE;
                        if (w_new_kind == K_ILL) begin
                            r_illegal <= 1'b1;
                            r_pc_en   <= 1'b1;
                        end
                    end else begin
                        r_ir_load <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_busy <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                    r_mem_cnt <= '0;
`endif
                    case (w_kind)
                        K_ILL: begin
                            r_state   <= S_FETCH;
                            r_ir_load <= 1'b1;
                        end
                        K_LD: begin
                            r_state   <= S_MEM;
                            r_memread <= 1'b1;
                        end
                        K_ST: begin
                            r_state    <= S_MEM;
                            r_memwrite <= 1'b1;
                        end
                        default: begin
                            r_state <= S_EXEC;
                            case (w_kind)
                                K_ALU: begin
                                    r_aluop    <= ALUOP_W'(r_op[2:0]);
                                    r_acc_ctrl <= 2'b01;
                                    r_acc_we   <= 1'b1;
                                    r_pc_en    <= 1'b1;
                                end
                                K_BZ: begin
                                    r_pc_en <= 1'b1;
                                    r_br    <= zero_flag;
                                end
                                K_BR: begin
                                    r_pc_en <= 1'b1;
                                    r_br    <= 1'b1;
                                end
                                K_MOVA: begin
                                    r_regwrite <= 1'b1;
                                    r_pc_en    <= 1'b1;
                                end
                                K_MOVR: begin
                                    r_acc_ctrl <= 2'b11;
                                    r_acc_we   <= 1'b1;
                                    r_pc_en    <= 1'b1;
                                end
                                K_NOP:  r_pc_en <= 1'b1;
                                K_IMM: begin
                                    r_acc_ctrl <= 2'b00;
                                    r_acc_we   <= 1'b1;
                                    r_pc_en    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                S_EXEC: begin
                    if (w_kind == K_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state   <= S_FETCH;
                        r_ir_load <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_MEM: begin
                    r_busy <= 1'b1;
                    if (mem_ready) begin
                        r_state <= S_WB;
                        r_pc_en <= 1'b1;
                        if (w_kind == K_LD) begin
                            r_acc_ctrl <= 2'b10;
                            r_acc_we   <= 1'b1;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (r_mem_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state   <= S_FETCH;
                        r_ir_load <= 1'b1;
                        r_pc_en   <= 1'b1;
                        r_timeout <= 1'b1;
`endif
                    end else begin
                        r_memread  <= (w_kind == K_LD);
                        r_memwrite <= (w_kind == K_ST);
`ifdef MEM_TIMEOUT_EN
                        r_mem_cnt  <= r_mem_cnt + 1'b1;
`endif
                    end
                end
                S_WB: begin
                    r_state   <= S_FETCH;
                    r_ir_load <= 1'b1;
                    r_busy    <= 1'b1;
                end
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_ir_load <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_halted <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ir_load       = r_ir_load;
    assign pc_en         = r_pc_en;
    assign br_ctrl       = r_br;
    assign regwrite_ctrl = r_regwrite;
    assign aluop_ctrl    = r_aluop;
    assign memread_ctrl  = r_memread;
    assign memwrite_ctrl = r_memwrite;
    assign acc_ctrl      = r_acc_ctrl;
    assign acc_we        = r_acc_we;
    assign busy          = r_busy;
    assign halted        = r_halted;
    assign illegal       = r_illegal;
    assign timeout       = r_timeout;

endmodule
